// File: rtl/bist_engine.sv
// BIST engine: Galois LFSR pattern generator, parallel MISR response compactor and
// start/busy/done controller. Define BIST_HOLD_EN to add a hold input that stalls a run.
module bist_engine #(
    parameter int                LFSR_W       = 5,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 5'b00100,
    parameter int                SIG_W        = 4,
    parameter logic [SIG_W-1:0]  SIG_TAPS     = 4'b0010,
    parameter int                NUM_PATTERNS = 31,
    parameter logic [SIG_W-1:0]  GOLDEN       = 4'h0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              abort,
    output logic [LFSR_W-1:0] pat,
    input  logic [SIG_W-1:0]  resp,
`ifdef BIST_HOLD_EN
    input  logic              hold,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  sig
);

    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [LFSR_W-1:0] lfsr, lfsr_d;
    logic [SIG_W-1:0]  sig_q, sig_d, sig_upd;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              pass_q, pass_d;
    logic              step;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        logic [LFSR_W-1:0] n;
        n[0] = q[LFSR_W-1];
        for (int k = 1; k < LFSR_W; k++) begin
            n[k] = q[k-1] ^ (LFSR_TAPS[k] & q[LFSR_W-1]);
        end
        return n;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [SIG_W-1:0] r);
        logic [SIG_W-1:0] m;
        m[0] = s[SIG_W-1] ^ r[0];
        for (int k = 1; k < SIG_W; k++) begin
            m[k] = s[k-1] ^ (SIG_TAPS[k] & s[SIG_W-1]) ^ r[k];
        end
        return m;
    endfunction

    // A held cycle neither shifts the LFSR nor absorbs a response nor counts.
`ifdef BIST_HOLD_EN
    assign step = ~hold;
`else
    assign step = 1'b1;
`endif

    assign sig_upd = misr_next(sig_q, resp);

    // NOTE: every target gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_d = state;
        lfsr_d  = lfsr;
        sig_d   = sig_q;
        cnt_d   = cnt;
        pass_d  = pass_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = '1;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                // Abort wins over the terminal count and leaves sig/lfsr where they were.
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (step) begin
                    sig_d  = sig_upd;
                    lfsr_d = lfsr_next(lfsr);
                    cnt_d  = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_d = S_DONE;
                        pass_d  = (sig_upd == GOLDEN);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= S_IDLE;
            lfsr   <= '1;
            sig_q  <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_d;
            lfsr   <= lfsr_d;
            sig_q  <= sig_d;
            cnt    <= cnt_d;
            pass_q <= pass_d;
        end
    end

    assign pat  = lfsr;
    assign sig  = sig_q;
    assign pass = pass_q;
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
